// File: rtl/sa_row_skewer.sv
// -----------------------------------------------------------------------------
// sa_row_skewer
//
// Purpose
//   Feeds the left edge of a systolic array. Every accepted activation vector
//   is split into ROWS lanes, and lane r is delayed by r extra cycles. The
//   result is the diagonal wavefront that the array rows expect. The array
//   never stalls, so the delay chains shift on every cycle. Cycles without an
//   accepted beat inject bubbles, which carry data 0 and valid 0.
//
//   A small FSM tracks tile boundaries. After the beat flagged with i_last is
//   accepted, the block stops accepting input. It waits until that beat has
//   reached the last row. It then pulses o_done and returns to IDLE.
//
// Parameters
//   ROWS    number of array rows fed (1..16)
//   MUL_BW  activation lane width (bf16 = 16)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   i_valid     upstream beat valid
//   i_data      activation vector, lane r = bits [r*MUL_BW +: MUL_BW]
//   i_last      final beat of a tile (only meaningful on accept)
//   o_ready     a beat can be accepted this cycle
//   o_left      skewed activations, lane r -> i_left of array row r
//   o_left_vld  per-lane flag: 1 = real activation, 0 = bubble
//   o_busy      high in STREAM, DRAIN and DONE
//   o_done      one-cycle pulse when the last beat reaches row ROWS-1
//   o_beat_cnt  beats accepted in the current (or most recent) tile
// -----------------------------------------------------------------------------
module sa_row_skewer #(
    parameter int ROWS   = 4,
    parameter int MUL_BW = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    input  logic [ROWS*MUL_BW-1:0]   i_data,
    input  logic                     i_last,
    output logic                     o_ready,
    output logic [ROWS*MUL_BW-1:0]   o_left,
    output logic [ROWS-1:0]          o_left_vld,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [15:0]              o_beat_cnt
);

    localparam int CNT_W = 5;

    // The drain counter is loaded on DRAIN entry and expires at zero. This
    // gives ROWS-1 DRAIN cycles followed by one DONE cycle. DONE therefore
    // lines up with the last beat leaving lane ROWS-1.
    localparam logic [CNT_W-1:0] DRAIN_LOAD = (ROWS > 1) ? CNT_W'(ROWS - 2) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [15:0]        beat_cnt_q, beat_cnt_d;
    logic               ready_c;
    logic               accept;
    logic [ROWS*MUL_BW-1:0] head_dat;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign accept   = i_valid & ready_c;
    // Zero data on non-accept cycles, so bubble lanes present 0 rather than stale data.
    assign head_dat = accept ? i_data : '0;

    // ---------------------------------------------------------------------
    // Control FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM: next state and outputs
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        ready_c     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ready_c = 1'b1;
                if (i_valid) begin
                    // The first beat of a tile restarts the count at 1.
                    beat_cnt_d = 16'd1;
                    if (i_last) begin
                        if (ROWS > 1) begin
                            state_d     = S_DRAIN;
                            drain_cnt_d = DRAIN_LOAD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        state_d = S_STREAM;
                    end
                end
            end

            S_STREAM: begin
                ready_c = 1'b1;
                if (i_valid) begin
                    beat_cnt_d = sat_inc16(beat_cnt_q);
                    if (i_last) begin
                        if (ROWS > 1) begin
                            state_d     = S_DRAIN;
                            drain_cnt_d = DRAIN_LOAD;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end

            S_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_ready    = ready_c;
    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = (state_q == S_DONE);
    assign o_beat_cnt = beat_cnt_q;

    // ---------------------------------------------------------------------
    // Per-lane delay chains: lane r holds r+1 registers.
    // The newest entry sits in the low slice and the oldest drives o_left.
    // ---------------------------------------------------------------------
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [(r+1)*MUL_BW-1:0] dat_q, dat_d;
        logic [r:0]              vld_q, vld_d;

        if (r == 0) begin : g_head
            assign dat_d = head_dat[MUL_BW-1:0];
            assign vld_d = accept;
        end else begin : g_tail
            assign dat_d = {dat_q[r*MUL_BW-1:0], head_dat[r*MUL_BW +: MUL_BW]};
            assign vld_d = {vld_q[r-1:0], accept};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                dat_q <= '0;
                vld_q <= '0;
            end else begin
                dat_q <= dat_d;
                vld_q <= vld_d;
            end
        end

        assign o_left[r*MUL_BW +: MUL_BW] = dat_q[r*MUL_BW +: MUL_BW];
        assign o_left_vld[r]              = vld_q[r];
    end

endmodule

// File: tb/tb_sa_row_skewer.sv
module tb_sa_row_skewer;

    localparam int ROWS   = 4;
    localparam int MUL_BW = 16;
    localparam int W      = ROWS * MUL_BW;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_valid;
    logic [W-1:0]   i_data;
    logic           i_last;
    logic           o_ready;
    logic [W-1:0]   o_left;
    logic [ROWS-1:0] o_left_vld;
    logic           o_busy;
    logic           o_done;
    logic [15:0]    o_beat_cnt;

    // ROWS=1 instance
    logic           v1;
    logic [15:0]    d1;
    logic           l1;
    logic           ready1;
    logic [15:0]    left1;
    logic [0:0]     vld1;
    logic           busy1;
    logic           done1;
    logic [15:0]    cnt1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sa_row_skewer #(.ROWS(ROWS), .MUL_BW(MUL_BW)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
        .o_ready(o_ready), .o_left(o_left), .o_left_vld(o_left_vld),
        .o_busy(o_busy), .o_done(o_done), .o_beat_cnt(o_beat_cnt)
    );

    sa_row_skewer #(.ROWS(1), .MUL_BW(MUL_BW)) dut1 (
        .clk(clk), .rst(rst), .i_valid(v1), .i_data(d1), .i_last(l1),
        .o_ready(ready1), .o_left(left1), .o_left_vld(vld1),
        .o_busy(busy1), .o_done(done1), .o_beat_cnt(cnt1)
    );

    // ------------------------------------------------------------------
    // Reference model.
    // History of the last ROWS edges, where index a = accepted a edges ago.
    // Lane r shows lane r of the beat accepted exactly r edges ago.
    // m_age counts edges since the last-beat accept (-1 = none pending).
    // The block refuses input for ROWS cycles and signals done when age is ROWS-1.
    // ------------------------------------------------------------------
    logic         m_acc [ROWS];
    logic [W-1:0] m_dat [ROWS];
    int           m_age    = -1;
    logic         m_intile = 1'b0;
    logic [15:0]  m_cnt    = 16'd0;

    initial begin
        for (int i = 0; i < ROWS; i++) begin
            m_acc[i] = 1'b0;
            m_dat[i] = '0;
        end
    end

    function automatic void model_edge(input logic v, input logic [W-1:0] d,
                                       input logic l, input logic r);
        logic acc;
        acc = !r && v && (m_age < 0);
        for (int i = ROWS - 1; i > 0; i--) begin
            m_acc[i] = m_acc[i-1];
            m_dat[i] = m_dat[i-1];
        end
        m_acc[0] = acc;
        m_dat[0] = acc ? d : '0;
        if (r) begin
            for (int i = 0; i < ROWS; i++) begin
                m_acc[i] = 1'b0;
                m_dat[i] = '0;
            end
            m_age    = -1;
            m_cnt    = 16'd0;
            m_intile = 1'b0;
            return;
        end
        if (m_age >= 0) begin
            m_age++;
            if (m_age >= ROWS) m_age = -1;
        end
        if (acc) begin
            if (!m_intile) begin
                m_cnt    = 16'd1;
                m_intile = 1'b1;
            end else if (m_cnt != 16'hFFFF) begin
                m_cnt = m_cnt + 16'd1;
            end
            if (l) begin
                m_intile = 1'b0;
                m_age    = 0;
            end
        end
    endfunction

    function automatic logic [W-1:0] exp_left();
        logic [W-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            if (m_acc[r]) v[r*MUL_BW +: MUL_BW] = m_dat[r][r*MUL_BW +: MUL_BW];
        return v;
    endfunction

    function automatic logic [ROWS-1:0] exp_vld();
        logic [ROWS-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r] = m_acc[r];
        return v;
    endfunction

    function automatic logic exp_ready();
        return m_age < 0;
    endfunction

    function automatic logic exp_done();
        return m_age == ROWS - 1;
    endfunction

    function automatic logic exp_busy();
        return m_intile || (m_age >= 0);
    endfunction

    function automatic logic [W-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    // Drive one cycle, advance the model at the edge, then settle before sampling.
    task automatic tick(input logic v, input logic [W-1:0] d, input logic l, input logic r);
        i_valid = v;
        i_data  = d;
        i_last  = l;
        rst     = r;
        @(posedge clk);
        model_edge(v, d, l, r);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        v1 = 1'b0; d1 = '0; l1 = 1'b0;
        tick(1'b1, rnd_data(), 1'b1, 1'b1);
        tick(1'b1, rnd_data(), 1'b0, 1'b1);
        n_assert++; if (o_left !== '0) begin n_fail++; $display("FAIL reset_left got %h exp 0", o_left); end
        n_assert++; if (o_left_vld !== '0) begin n_fail++; $display("FAIL reset_vld got %b exp 0", o_left_vld); end
        n_assert++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        n_assert++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", o_done); end
        n_assert++; if (o_beat_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", o_beat_cnt); end
        n_assert++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", o_ready); end
        tick(1'b0, '0, 1'b0, 1'b0);
        n_assert++; if (o_left_vld !== '0) begin n_fail++; $display("FAIL reset_no_accept got %b exp 0", o_left_vld); end
    endtask

    task automatic test_single();
        logic [W-1:0] d;
        int done_at, not_ready;
        d = {16'h4080, 16'h4040, 16'h3F80, 16'h4000};
        done_at = -1; not_ready = 0;
        tick(1'b1, d, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            n_assert++; if (o_left !== exp_left()) begin n_fail++; $display("FAIL single_left c%0d got %h exp %h", i, o_left, exp_left()); end
            n_assert++; if (o_left_vld !== exp_vld()) begin n_fail++; $display("FAIL single_vld c%0d got %b exp %b", i, o_left_vld, exp_vld()); end
            n_assert++; if (o_ready !== exp_ready()) begin n_fail++; $display("FAIL single_ready c%0d got %b exp %b", i, o_ready, exp_ready()); end
            if (o_done === 1'b1) done_at = i;
            if (o_ready === 1'b0) not_ready++;
            if (i == 3) begin
                n_assert++; if (o_left[3*MUL_BW +: MUL_BW] !== 16'h4080) begin n_fail++; $display("FAIL single_lane3 got %h exp 4080", o_left[3*MUL_BW +: MUL_BW]); end
            end
            tick(1'b0, '0, 1'b0, 1'b0);
        end
        n_assert++; if (done_at != 3) begin n_fail++; $display("FAIL single_done_at got %0d exp 3", done_at); end
        n_assert++; if (not_ready != 4) begin n_fail++; $display("FAIL single_not_ready got %0d exp 4", not_ready); end
        n_assert++; if (o_beat_cnt !== 16'd1) begin n_fail++; $display("FAIL single_cnt got %0d exp 1", o_beat_cnt); end
    endtask

    task automatic test_stream();
        int done_at;
        done_at = -1;
        for (int i = 0; i < 13; i++) begin
            if (i < 5) tick(1'b1, rnd_data(), (i == 4), 1'b0);
            else       tick(1'b0, '0, 1'b0, 1'b0);
            n_assert++; if (o_left !== exp_left()) begin n_fail++; $display("FAIL stream_left c%0d got %h exp %h", i, o_left, exp_left()); end
            n_assert++; if (o_left_vld !== exp_vld()) begin n_fail++; $display("FAIL stream_vld c%0d got %b exp %b", i, o_left_vld, exp_vld()); end
            n_assert++; if (o_busy !== exp_busy()) begin n_fail++; $display("FAIL stream_busy c%0d got %b exp %b", i, o_busy, exp_busy()); end
            n_assert++; if (o_done !== exp_done()) begin n_fail++; $display("FAIL stream_done c%0d got %b exp %b", i, o_done, exp_done()); end
            n_assert++; if (o_beat_cnt !== m_cnt) begin n_fail++; $display("FAIL stream_cnt c%0d got %0d exp %0d", i, o_beat_cnt, m_cnt); end
            if (o_done === 1'b1) done_at = i;
        end
        n_assert++; if (done_at != 7) begin n_fail++; $display("FAIL stream_done_at got %0d exp 7", done_at); end
        n_assert++; if (o_beat_cnt !== 16'd5) begin n_fail++; $display("FAIL stream_final_cnt got %0d exp 5", o_beat_cnt); end
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 9; i++) begin
            if (i < 3) tick((i != 1), rnd_data(), (i == 2), 1'b0);
            else       tick(1'b0, '0, 1'b0, 1'b0);
            n_assert++; if (o_left !== exp_left()) begin n_fail++; $display("FAIL gapped_left c%0d got %h exp %h", i, o_left, exp_left()); end
            n_assert++; if (o_left_vld !== exp_vld()) begin n_fail++; $display("FAIL gapped_vld c%0d got %b exp %b", i, o_left_vld, exp_vld()); end
            // The bubble sits on lane r during the cycle after edge 1+r.
            if (i >= 1 && i <= 4) begin
                n_assert++;
                if (o_left_vld[i-1] !== 1'b0 || o_left[(i-1)*MUL_BW +: MUL_BW] !== 16'h0) begin
                    n_fail++; $display("FAIL gapped_bubble lane%0d got vld %b data %h exp 0", i-1, o_left_vld[i-1], o_left[(i-1)*MUL_BW +: MUL_BW]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            if (i < 12) tick(1'b1, rnd_data(), (i == 1 || i == 9), 1'b0);
            else        tick(1'b0, '0, 1'b0, 1'b0);
            n_assert++; if (o_ready !== exp_ready()) begin n_fail++; $display("FAIL b2b_ready c%0d got %b exp %b", i, o_ready, exp_ready()); end
            n_assert++; if (o_left !== exp_left()) begin n_fail++; $display("FAIL b2b_left c%0d got %h exp %h", i, o_left, exp_left()); end
            n_assert++; if (o_left_vld !== exp_vld()) begin n_fail++; $display("FAIL b2b_vld c%0d got %b exp %b", i, o_left_vld, exp_vld()); end
            n_assert++; if (o_beat_cnt !== m_cnt) begin n_fail++; $display("FAIL b2b_cnt c%0d got %0d exp %0d", i, o_beat_cnt, m_cnt); end
            n_assert++; if (o_done !== exp_done()) begin n_fail++; $display("FAIL b2b_done c%0d got %b exp %b", i, o_done, exp_done()); end
        end
        n_assert++; if (o_beat_cnt !== 16'd4) begin n_fail++; $display("FAIL b2b_final_cnt got %0d exp 4", o_beat_cnt); end
    endtask

    task automatic test_reset_drain();
        tick(1'b1, rnd_data(), 1'b1, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);
        tick(1'b1, rnd_data(), 1'b0, 1'b1);
        n_assert++; if (o_left !== '0) begin n_fail++; $display("FAIL rstdrain_left got %h exp 0", o_left); end
        n_assert++; if (o_left_vld !== '0) begin n_fail++; $display("FAIL rstdrain_vld got %b exp 0", o_left_vld); end
        n_assert++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstdrain_busy got %b exp 0", o_busy); end
        n_assert++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rstdrain_ready got %b exp 1", o_ready); end
        n_assert++; if (o_beat_cnt !== 16'd0) begin n_fail++; $display("FAIL rstdrain_cnt got %0d exp 0", o_beat_cnt); end
        for (int i = 0; i < 4; i++) begin
            n_assert++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL rstdrain_done c%0d got %b exp 0", i, o_done); end
            tick(1'b0, '0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 120; i++) begin
            if (i < 110) tick(($urandom_range(0, 9) < 7), rnd_data(), ($urandom_range(0, 9) < 2), 1'b0);
            else         tick(1'b0, '0, 1'b0, 1'b0);
            n_assert++; if (o_left !== exp_left()) begin n_fail++; $display("FAIL rand_left c%0d got %h exp %h", i, o_left, exp_left()); end
            n_assert++; if (o_left_vld !== exp_vld()) begin n_fail++; $display("FAIL rand_vld c%0d got %b exp %b", i, o_left_vld, exp_vld()); end
            n_assert++; if (o_ready !== exp_ready()) begin n_fail++; $display("FAIL rand_ready c%0d got %b exp %b", i, o_ready, exp_ready()); end
            n_assert++; if (o_busy !== exp_busy()) begin n_fail++; $display("FAIL rand_busy c%0d got %b exp %b", i, o_busy, exp_busy()); end
            n_assert++; if (o_done !== exp_done()) begin n_fail++; $display("FAIL rand_done c%0d got %b exp %b", i, o_done, exp_done()); end
            n_assert++; if (o_beat_cnt !== m_cnt) begin n_fail++; $display("FAIL rand_cnt c%0d got %0d exp %0d", i, o_beat_cnt, m_cnt); end
        end
    endtask

    task automatic test_rows1();
        logic [15:0] d;
        d = 16'($urandom);
        v1 = 1'b1; d1 = d; l1 = 1'b1;
        tick(1'b0, '0, 1'b0, 1'b0);
        n_assert++; if (left1 !== d) begin n_fail++; $display("FAIL rows1_left got %h exp %h", left1, d); end
        n_assert++; if (vld1 !== 1'b1) begin n_fail++; $display("FAIL rows1_vld got %b exp 1", vld1); end
        n_assert++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL rows1_done got %b exp 1", done1); end
        n_assert++; if (ready1 !== 1'b0) begin n_fail++; $display("FAIL rows1_ready got %b exp 0", ready1); end
        n_assert++; if (cnt1 !== 16'd1) begin n_fail++; $display("FAIL rows1_cnt got %0d exp 1", cnt1); end
        v1 = 1'b0; d1 = '0; l1 = 1'b0;
        tick(1'b0, '0, 1'b0, 1'b0);
        n_assert++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL rows1_done2 got %b exp 0", done1); end
        n_assert++; if (ready1 !== 1'b1 || busy1 !== 1'b0) begin n_fail++; $display("FAIL rows1_idle got ready %b busy %b exp 1 0", ready1, busy1); end
        n_assert++; if (vld1 !== 1'b0 || left1 !== 16'h0) begin n_fail++; $display("FAIL rows1_bubble got vld %b data %h exp 0 0", vld1, left1); end
        n_assert++; if (cnt1 !== 16'd1) begin n_fail++; $display("FAIL rows1_cnt_hold got %0d exp 1", cnt1); end
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0;
        v1 = 1'b0; d1 = '0; l1 = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_gapped();
        test_back_to_back();
        test_reset_drain();
        test_random();
        test_rows1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_row_skewer.md
SA_ROW_SKEWER -- requirements
Module: sa_row_skewer

Interface
REQ-001 Parameter ROWS, default 4: number of array rows fed, range 1..16.
REQ-002 Parameter MUL_BW, default 16: bf16 activation lane width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_valid  input  1  upstream beat valid.
REQ-006 i_data  input  ROWS*MUL_BW  one activation vector; lane r = bits [r*MUL_BW +: MUL_BW].
REQ-007 i_last  input  1  qualifies the final beat of a tile; sampled only on accept.
REQ-008 o_ready  output  1  block can accept a beat this cycle.
REQ-009 o_left  output  ROWS*MUL_BW  skewed activations; lane r drives the i_left port of array row r.
REQ-010 o_left_vld  output  ROWS  per-row flag: lane r carries a real activation, not a bubble.
REQ-011 o_busy  output  1  high in STREAM, DRAIN, DONE.
REQ-012 o_done  output  1  one-cycle pulse: last beat fully presented to all rows.
REQ-013 o_beat_cnt  output  16  beats accepted in the current tile.

Function
REQ-014 Accept occurs at an edge where i_valid=1 and o_ready=1; i_valid with o_ready=0 is ignored and not buffered.
REQ-015 Lane r of a beat accepted at edge k appears on o_left lane r, with o_left_vld[r]=1, for exactly one cycle, starting after edge k+r (lane 0 latency 1 cycle, lane r latency r+1 cycles).
REQ-016 Implementation: per-lane delay chain of depth r+1 registers, data and valid shifted every cycle unconditionally; the array has no stall.
REQ-017 A cycle with no accept injects a bubble: data 0, valid 0, into every chain head.
REQ-018 Bubble lanes output o_left lane = 0; o_left is never X after reset.
REQ-019 FSM states: IDLE, STREAM, DRAIN, DONE.
REQ-020 IDLE: o_ready=1; accept without i_last -> STREAM; accept with i_last -> DRAIN (ROWS>1) or DONE (ROWS=1).
REQ-021 STREAM: o_ready=1; accept with i_last -> DRAIN (ROWS>1) or DONE (ROWS=1); otherwise remain.
REQ-022 DRAIN: o_ready=0; down-counter loaded ROWS-2 on entry, decrements each cycle; at 0 -> DONE. DRAIN lasts exactly ROWS-1 cycles.
REQ-023 DONE: o_ready=0, o_done=1 for one cycle -> IDLE. o_done is coincident with the last beat's lane ROWS-1 on o_left.
REQ-024 o_beat_cnt increments on each accept, saturates at 16'hFFFF, and clears on the IDLE->STREAM/DRAIN/DONE transition before counting the first beat, so it reads 1 after the first accept.
REQ-025 o_beat_cnt holds its value through DRAIN/DONE and IDLE until the next tile's first accept.
REQ-026 Back-to-back tiles: the first beat of the next tile is accepted no earlier than the cycle after o_done (IDLE), giving ROWS cycles of o_ready=0 per tile boundary.
REQ-027 i_last on a non-accepted cycle has no effect.

Reset
REQ-028 rst=1 at an edge: FSM -> IDLE, all chain data and valid bits -> 0, counters -> 0, regardless of the current state (including mid-DRAIN).
REQ-029 Outputs after reset: o_left=0, o_left_vld=0, o_busy=0, o_done=0, o_beat_cnt=0, o_ready=1.
REQ-030 A beat presented while rst=1 is not accepted.

Verification (ROWS=4, MUL_BW=16)
REQ-031 Single beat: i_data lanes {0x4000,0x3F80,0x4040,0x4080} with i_last at edge k -> lane r = value r with vld[r]=1 only after edge k+r; o_ready=0 for cycles k+1..k+4; o_done after edge k+3; o_beat_cnt=1.
REQ-032 Stream of 5 consecutive beats, 5th with i_last -> each lane shows 5 consecutive valid values with no gaps; lane 3 first valid after edge k+3; o_done after edge k+7; o_beat_cnt=5.
REQ-033 Gapped input (valid 1,0,1 pattern) -> bubble cycle shows lane=0, vld=0, propagating diagonally across rows 0..3.
REQ-034 i_valid=1 held during DRAIN/DONE -> no accept, o_beat_cnt unchanged; accepted only after return to IDLE.
REQ-035 rst asserted during the 2nd DRAIN cycle -> next cycle all outputs match REQ-029; no o_done pulse.
REQ-036 ROWS=1 build: beat with i_last -> lane 0 valid after edge k, o_done in the same cycle, IDLE next.
